// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing, rgb332 pixel type and DAC channel expansion
package vga_timing_pkg;
    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int COORD_W = 11;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // Bit replication maps full-scale codes to 8'hFF and zero to 8'h00
    function automatic logic [7:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    function automatic logic [7:0] expand2(input logic [1:0] c);
        return {c, c, c, c};
    endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrapping raster counter for one axis; wrap flags the enabled terminal step
module vga_axis_counter #(
    parameter int TOTAL = 800,
    parameter int W     = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         wrap
);
    assign wrap = enable && (count == W'(TOTAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (enable)
            count <= wrap ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: raster timing generator and VGA DAC output stage with one pixel of aligned latency
module vga_scanout
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV     = DEF_CLK_DIV,
    parameter int   H_VISIBLE   = DEF_H_VISIBLE,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_VISIBLE   = DEF_V_VISIBLE,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  RGBIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hSync,
    output logic        vSync,
    output logic        blankN
);
    localparam int H_PERIOD = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_PERIOD = V_VISIBLE + V_FP + V_SYNC + V_BP;

    logic [2:0] div;
    logic       strobe;
    logic       h_wrap;
    logic       v_wrap;
    logic       active;
    logic       in_hs;
    logic       in_vs;
    rgb332_t    px;

    assign strobe = div == 3'(CLK_DIV - 1);
    assign px     = RGBIn;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            div <= '0;
        else
            div <= strobe ? '0 : div + 3'd1;
    end

    vga_axis_counter #(.TOTAL(H_PERIOD), .W(COORD_W)) u_h (
        .clk    (clk),
        .rst_n  (resetN),
        .enable (strobe),
        .count  (pixelX),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_PERIOD), .W(COORD_W)) u_v (
        .clk    (clk),
        .rst_n  (resetN),
        .enable (h_wrap),
        .count  (pixelY),
        .wrap   (v_wrap)
    );

    // Decoded from the pre-strobe coordinate, i.e. the pixel whose colour RGBIn now holds
    always_comb begin
        active = (pixelX < 11'(H_VISIBLE)) && (pixelY < 11'(V_VISIBLE));
        in_hs  = (pixelX >= 11'(H_VISIBLE + H_FP)) && (pixelX < 11'(H_VISIBLE + H_FP + H_SYNC));
        in_vs  = (pixelY >= 11'(V_VISIBLE + V_FP)) && (pixelY < 11'(V_VISIBLE + V_FP + V_SYNC));
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            red          <= '0;
            green        <= '0;
            blue         <= '0;
            blankN       <= 1'b0;
            hSync        <= ~SYNC_ACTIVE;
            vSync        <= ~SYNC_ACTIVE;
            startOfFrame <= 1'b0;
        end else begin
            startOfFrame <= v_wrap;
            if (strobe) begin
                red    <= active ? expand3(px.r) : 8'h00;
                green  <= active ? expand3(px.g) : 8'h00;
                blue   <= active ? expand2(px.b) : 8'h00;
                blankN <= active;
                hSync  <= in_hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                vSync  <= in_vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            end
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: random-colour run against a clock-count raster model; full-width lines, short frames
module tb_vga_scanout;
    localparam int DIV = 2;
    localparam int HV = 640, HFP = 16, HS = 96, HB = 48;
    localparam int VV = 8, VFP = 2, VS = 2, VB = 3;
    localparam int HT = HV + HFP + HS + HB;
    localparam int VT = VV + VFP + VS + VB;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [7:0]  RGBIn = 8'h00;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame, hSync, vSync, blankN;
    logic [7:0]  red, green, blue;

    vga_scanout #(
        .CLK_DIV(DIV), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE(1'b0)
    ) dut (
        .clk(clk), .resetN(resetN), .RGBIn(RGBIn),
        .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
        .red(red), .green(green), .blue(blue),
        .hSync(hSync), .vSync(vSync), .blankN(blankN)
    );

    always #10 clk = ~clk;

    int         asserts = 0;
    int         fails = 0;
    longint     n = 0;
    logic [7:0] sampled = 8'h00;
    int         hs_low = 0;
    int         sof_cnt = 0;
    logic [7:0] pats [6] = '{8'hE0, 8'h1C, 8'h03, 8'h92, 8'hFF, 8'h00};

    task automatic check(input string tag, input longint obs, input longint exp);
        asserts++;
        if (obs != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (clk %0d after release)", tag, obs, exp, n);
        end
    endtask

    function automatic longint chan3(input int c);
        return c * 36 + c / 2;
    endfunction

    task automatic expect_reset(input string ph);
        check({ph, "_pixelX"}, pixelX, 0);
        check({ph, "_pixelY"}, pixelY, 0);
        check({ph, "_sof"}, startOfFrame, 0);
        check({ph, "_red"}, red, 0);
        check({ph, "_green"}, green, 0);
        check({ph, "_blue"}, blue, 0);
        check({ph, "_blankN"}, blankN, 0);
        check({ph, "_hSync"}, hSync, 1);
        check({ph, "_vSync"}, vSync, 1);
    endtask

    task automatic compare_model();
        longint p = n / DIV;
        longint q = p - 1;
        longint x = q % HT;
        longint y = (q / HT) % VT;
        bit act = (p > 0) && x < HV && y < VV;
        bit hs = (p > 0) && x >= HV + HFP && x < HV + HFP + HS;
        bit vs = (p > 0) && y >= VV + VFP && y < VV + VFP + VS;
        check("pixelX", pixelX, p % HT);
        check("pixelY", pixelY, (p / HT) % VT);
        check("sof", startOfFrame, longint'(n % DIV == 0 && p > 0 && p % (HT * VT) == 0));
        check("red", red, act ? chan3(int'(sampled[7:5])) : 0);
        check("green", green, act ? chan3(int'(sampled[4:2])) : 0);
        check("blue", blue, act ? longint'(sampled[1:0]) * 85 : 0);
        check("blankN", blankN, longint'(act));
        check("hSync", hSync, longint'(!hs));
        check("vSync", vSync, longint'(!vs));
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        if (n % DIV == 0) sampled = RGBIn;
        @(negedge clk);
        compare_model();
        if (n <= 3200 && !hSync) hs_low++;
        if (startOfFrame) sof_cnt++;
        RGBIn = ($urandom_range(0, 2) == 0) ? pats[$urandom_range(0, 5)] : 8'($urandom);
    endtask

    initial begin
        bit hit;
        repeat (3) @(negedge clk);
        expect_reset("rst");
        resetN = 1'b1;
        n = 0;
        for (int i = 0; i < 30000; i++) step();
        check("hs_clks_2lines", hs_low, 384);
        hit = 1'b0;
        for (int i = 0; i < HT * VT * DIV && !hit; i++) begin
            step();
            hit = pixelX == 11'd320 && pixelY == 11'd5;
        end
        check("mid_found", hit, 1);
        check("sof_frame1", sof_cnt, 1);
        #3 resetN = 1'b0;
        #1 expect_reset("async");
        @(negedge clk);
        expect_reset("held");
        resetN = 1'b1;
        n = 0;
        sampled = 8'h00;
        sof_cnt = 0;
        for (int i = 0; i < 25000; i++) step();
        check("sof_frame2", sof_cnt, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule

// File: doc/vga_scanout.md
# vga_scanout

Pixel-rate raster controller and display output stage: generates 640x480@60 timing, presents the current pixel coordinate to all drawing objects, takes the registered 8-bit RRRGGGBB pixel back from the object priority mux, and drives the VGA DAC (8 bits per channel) with aligned sync/blank. It closes the render loop: coordinates out, priority-muxed colour in, one pixel of latency, absorbed internally.

## Interface
- CLK_DIV, 2: clk cycles per pixel (50 MHz clk -> 25 MHz pixel); legal 2..8
- H_VISIBLE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48: horizontal timing in pixels
- V_VISIBLE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33: vertical timing in lines
- SYNC_ACTIVE, 1'b0: active level of hSync/vSync
- clk  in  1  system clock, one clock domain
- resetN  in  1  asynchronous, active-low reset
- RGBIn  in  8  colour from object mux, {R[2:0],G[2:0],B[1:0]}, registered upstream
- pixelX  out  11  current horizontal count, 0..H_TOTAL-1
- pixelY  out  11  current vertical count, 0..V_TOTAL-1
- startOfFrame  out  1  one-clk pulse when counters wrap to (0,0)
- red / green / blue  out  8 each  DAC channel values
- hSync / vSync  out  1 each  sync outputs, SYNC_ACTIVE polarity
- blankN  out  1  low outside visible area

## Operation
- H_TOTAL = sum of H params (800), V_TOTAL = sum of V params (525).
- Divider counts 0..CLK_DIV-1; pixel strobe asserted on clk where divider == CLK_DIV-1.
- On strobe: hCount wraps at H_TOTAL-1 to 0, else +1; vCount advances only on hCount wrap, wraps at V_TOTAL-1.
- pixelX/pixelY are the counter registers directly; change only on strobe.
- Output stage, also on strobe, from counter values held before that strobe (the pixel whose colour is on RGBIn):
  - active = hCount < H_VISIBLE and vCount < V_VISIBLE
  - hSync = SYNC_ACTIVE when H_VISIBLE+H_FP <= hCount < H_VISIBLE+H_FP+H_SYNC, else inactive; vSync analogous on vCount
  - blankN = active; red/green/blue = active ? expand(RGBIn) : 0
- Expansion: red = {R,R,R[2:1]}, green = {G,G,G[2:1]}, blue = {B,B,B,B}; thus 3'b111 -> 8'hFF, 3'b000 -> 8'h00.
- startOfFrame: registered, high for exactly one clk, the clk after the strobe that sets (hCount,vCount) to (0,0).
- No handshake: upstream objects are combinational on pixelX/Y, mux registers once; RGBIn is valid from one clk after coordinate change until next strobe.

## Timing
- Reset (async, immediate): divider, hCount, vCount = 0; red/green/blue = 0; blankN = 0; hSync/vSync = ~SYNC_ACTIVE; startOfFrame = 0.
- First strobe occurs CLK_DIV clks after resetN deasserts.
- Coordinate-to-DAC latency: exactly one pixel period; sync/blank carry the same delay, so all DAC-side outputs are aligned.
- RGBIn sampled only on strobe clk; CLK_DIV >= 2 guarantees mux settle (1 clk) before sampling.
- Line wrap and frame wrap on same strobe: both counters go to 0 together; no skipped line.
- Reset mid-frame: all state cleared asynchronously; restart at (0,0) with no partial sync pulse held.

## Structure
- Package vga_timing_pkg: default timing constants, H_TOTAL/V_TOTAL localparams, rgb332 type and expand functions.
- One sub-module, vga_axis_counter (parameterised TOTAL, enable in, count out, wrap out), instantiated for horizontal and vertical axes.

## Test plan
- Reset held then released: all outputs at reset values; first pixelX change 0->1 exactly 2 clks after release (CLK_DIV=2).
- Line timing: hSync active for hCount 656..751 delayed one pixel, i.e. 96 pixels = 192 clks per line; line period 1600 clks.
- Frame wrap: at (799,524) next strobe gives (0,0); startOfFrame one clk high; frame period 840000 clks.
- Colour: RGBIn=8'hE0 at visible pixel -> red=FF, green=00, blue=00 one pixel later; 8'h1C -> green=FF; 8'h03 -> blue=FF; 8'h92 -> red=92, green=92, blue=AA.
- Blanking: RGBIn=8'hFF held, pixelX in 640..799 -> DAC outputs 0, blankN=0; vSync active for lines 490..491.
- Reset asserted at (320,240): outputs return to reset values same clk; after release counting resumes at (0,0).
